// File: rtl/sram.sv
// Simple dual-port synchronous RAM: one write port with per-lane enables and one
// read port with a registered, optionally deeper, read pipeline. Reads are read-first.
module sram #(
    parameter int WIDTH    = 64,
    parameter int LOGDEPTH = 9,
    parameter int WORDSIZE = 64,
    parameter int PORTS    = 1,
    parameter int DELAY    = ((LOGDEPTH - 8 > 0 ? LOGDEPTH - 8 : 1) *
                              (PORTS > 1 ? (PORTS > 2 ? (PORTS > 3 ? 100 : 20) : 14) : 10)) / 10 - 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LOGDEPTH-1:0]          readAddr,
    output logic [WIDTH-1:0]             readData,
    input  logic [LOGDEPTH-1:0]          writeAddr,
    input  logic [WIDTH-1:0]             writeData,
    input  logic [WIDTH/WORDSIZE-1:0]    writeEnable
);

    localparam int LANES = WIDTH / WORDSIZE;
    localparam int DEPTH = 2 ** LOGDEPTH;

    logic [WIDTH-1:0] memArray_r [DEPTH];
    logic [WIDTH-1:0] readPipe_r [DELAY+1];

    // Write port: lane-masked update; the array itself is never cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                if (writeEnable[i]) begin
                    memArray_r[writeAddr][i*WORDSIZE +: WORDSIZE] <= writeData[i*WORDSIZE +: WORDSIZE];
                end
            end
        end
    end

    // Read pipeline: stage 0 samples the pre-write row contents, so collisions are read-first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k <= DELAY; k++) begin
                readPipe_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            readPipe_r[0] <= memArray_r[readAddr];
            for (int k = 1; k <= DELAY; k++) begin
                readPipe_r[k] <= readPipe_r[k-1];
            end
        end
    end

    assign readData = readPipe_r[DELAY];

endmodule

// File: tb/tb_sram.sv
// Randomized scoreboard bench for sram: a data-cache style instance, a tag-style
// instance and a three-stage read pipeline instance share one clock and reset.
module tb_sram;

    typedef struct {
        int           due;
        logic [511:0] exp;
        logic [511:0] mask;
    } ent_t;
    typedef ent_t q_t[$];

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    logic [8:0]   mRA = 9'd0, mWA = 9'd0;
    logic [511:0] mWD = '0, mRD;
    logic [7:0]   mWE = 8'd0;
    logic [8:0]   tRA = 9'd0, tWA = 9'd0;
    logic [51:0]  tWD = '0, tRD;
    logic [0:0]   tWE = 1'b0;
    logic [8:0]   dRA = 9'd0, dWA = 9'd0;
    logic [63:0]  dWD = '0, dRD;
    logic [3:0]   dWE = 4'd0;

    sram #(.WIDTH(512), .LOGDEPTH(9), .WORDSIZE(64), .PORTS(1)) uMain (
        .clk(clk), .reset(reset), .readAddr(mRA), .readData(mRD),
        .writeAddr(mWA), .writeData(mWD), .writeEnable(mWE));

    sram #(.WIDTH(52), .LOGDEPTH(9), .WORDSIZE(52), .PORTS(1)) uTag (
        .clk(clk), .reset(reset), .readAddr(tRA), .readData(tRD),
        .writeAddr(tWA), .writeData(tWD), .writeEnable(tWE));

    sram #(.WIDTH(64), .LOGDEPTH(9), .WORDSIZE(16), .PORTS(1), .DELAY(2)) uDly (
        .clk(clk), .reset(reset), .readAddr(dRA), .readData(dRD),
        .writeAddr(dWA), .writeData(dWD), .writeEnable(dWE));

    // Reference memories with a per-bit "has been written" mask (unwritten bits are don't-care).
    logic [511:0] mMem [512];
    logic [511:0] mKnown [512];
    logic [51:0]  tMem [512];
    logic [51:0]  tKnown [512];
    logic [63:0]  dMem [512];
    logic [63:0]  dKnown [512];

    q_t mQ, tQ, dQ;
    int tests = 0;
    int fails = 0;

    function automatic q_t trim(q_t q, int lim);
        q_t r;
        foreach (q[i]) if (q[i].due < lim) r.push_back(q[i]);
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [511:0] got, input ent_t e);
        tests++;
        if ((got & e.mask) !== (e.exp & e.mask)) begin
            fails++;
            $display("FAIL %s edge=%0d got=%h exp=%h", name, e.due, got & e.mask, e.exp & e.mask);
        end
    endtask

    // Monitor: compare every expectation whose data is due after the latest edge.
    always @(negedge clk) begin
        ent_t e;
        while (mQ.size() > 0 && mQ[0].due <= edges) begin
            e = mQ.pop_front();
            check("main", mRD, e);
        end
        while (tQ.size() > 0 && tQ[0].due <= edges) begin
            e = tQ.pop_front();
            check("tag", {460'd0, tRD}, e);
        end
        while (dQ.size() > 0 && dQ[0].due <= edges) begin
            e = dQ.pop_front();
            check("delay2", {448'd0, dRD}, e);
        end
    end

    // Model one normal edge: reads see the old contents, then lane writes apply.
    task automatic issue();
        ent_t e;
        if (mKnown[mRA] != '0) begin
            e.due = edges + 1; e.exp = mMem[mRA]; e.mask = mKnown[mRA];
            mQ.push_back(e);
        end
        if (tKnown[tRA] != '0) begin
            e.due = edges + 1; e.exp = {460'd0, tMem[tRA]}; e.mask = {460'd0, tKnown[tRA]};
            tQ.push_back(e);
        end
        if (dKnown[dRA] != '0) begin
            e.due = edges + 3; e.exp = {448'd0, dMem[dRA]}; e.mask = {448'd0, dKnown[dRA]};
            dQ.push_back(e);
        end
        for (int i = 0; i < 8; i++) if (mWE[i]) begin
            mMem[mWA][i*64 +: 64] = mWD[i*64 +: 64];
            mKnown[mWA][i*64 +: 64] = '1;
        end
        if (tWE[0]) begin
            tMem[tWA] = tWD;
            tKnown[tWA] = '1;
        end
        for (int i = 0; i < 4; i++) if (dWE[i]) begin
            dMem[dWA][i*16 +: 16] = dWD[i*16 +: 16];
            dKnown[dWA][i*16 +: 16] = '1;
        end
    endtask

    // Model a reset edge: in-flight reads are lost, outputs are zero until fresh data arrives.
    task automatic issueReset();
        ent_t e;
        mQ = trim(mQ, edges + 1);
        tQ = trim(tQ, edges + 1);
        dQ = trim(dQ, edges + 1);
        e.exp = '0;
        e.due = edges + 1; e.mask = '1;              mQ.push_back(e);
        e.due = edges + 1; e.mask = {460'd0, {52{1'b1}}}; tQ.push_back(e);
        for (int k = 1; k <= 3; k++) begin
            e.due = edges + k; e.mask = {448'd0, {64{1'b1}}}; dQ.push_back(e);
        end
    endtask

    task automatic tick();
        issue();
        @(posedge clk); #1;
        mWE = 8'd0; tWE = 1'b0; dWE = 4'd0;
    endtask

    task automatic resetTick();
        reset = 1'b0;
        issueReset();
        @(posedge clk); #1;
        reset = 1'b1;
        mWE = 8'd0; tWE = 1'b0; dWE = 4'd0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] pat;
        for (int i = 0; i < 512; i++) begin
            mKnown[i] = '0; tKnown[i] = '0; dKnown[i] = '0;
        end
        @(posedge clk); #1;
        resetTick();
        reset = 1'b0;
        resetTick();

        // Full-row write then read
        for (int i = 0; i < 8; i++) mWD[i*64 +: 64] = 64'h0123_4567_89AB_CDEF + 64'(i);
        mWA = 9'd5; mWE = 8'hFF; tick();
        mRA = 9'd5; tick();

        // Lane mask: only lane 2 cleared
        mWA = 9'd7; mWD = '1; mWE = 8'hFF; tick();
        mWD = '0; mWE = 8'b0000_0100; tick();
        mRA = 9'd7; tick();

        // Same-address collision is read-first
        mWA = 9'd3; mWD = {8{64'hAAAA_5555_AAAA_5555}}; mWE = 8'hFF; tick();
        mWD = {8{64'h1234_0000_FEDC_BBBB}}; mWE = 8'hFF; mRA = 9'd3; tick();
        mRA = 9'd3; tick();

        // Tag-style instance at the top address
        tWA = 9'd0; tWD = 52'h12345; tWE = 1'b1; tick();
        tWA = 9'd511; tWD = 52'hABCDE; tWE = 1'b1; tick();
        tRA = 9'd511; tick();
        tRA = 9'd0; tick();

        // Three-stage pipeline, back-to-back reads
        for (int k = 1; k <= 3; k++) begin
            dWA = 9'(k); dWD = 64'hD00D_0000_0000_0000 + 64'(k * 17); dWE = 4'hF; tick();
        end
        for (int k = 1; k <= 3; k++) begin
            dRA = 9'(k); tick();
        end

        // Reset suppresses the write to row 9 and clears the output
        pat = {8{64'h9999_0000_0000_9999}};
        mWA = 9'd9; mWD = pat; mWE = 8'hFF; tick();
        mRA = 9'd9; tick();
        mWA = 9'd9; mWD = ~pat; mWE = 8'hFF; mRA = 9'd5;
        resetTick();
        mRA = 9'd9; tick();
        mRA = 9'd5; tick();
        mRA = 9'd7; tick();

        // Randomized traffic over a small address pool to provoke collisions
        for (int n = 0; n < 600; n++) begin
            mRA = ($urandom_range(0, 9) == 0) ? 9'd511 : 9'($urandom_range(0, 15));
            mWA = ($urandom_range(0, 9) == 0) ? 9'd511 : 9'($urandom_range(0, 15));
            mWD = rnd512(); mWE = 8'($urandom);
            tRA = 9'($urandom_range(0, 7)); tWA = 9'($urandom_range(0, 7));
            tWD = {20'($urandom), 32'($urandom)}; tWE = 1'($urandom);
            dRA = 9'($urandom_range(0, 7)); dWA = 9'($urandom_range(0, 7));
            dWD = {32'($urandom), 32'($urandom)}; dWE = 4'($urandom);
            if ($urandom_range(0, 59) == 0) resetTick();
            else tick();
        end

        mWE = 8'd0; tWE = 1'b0; dWE = 4'd0;
        repeat (6) @(posedge clk);
        @(negedge clk); #1;
        tests++;
        if (mQ.size() + tQ.size() + dQ.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending expected=0", mQ.size() + tQ.size() + dQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
